// File: rtl/mem_access.sv
// Memory stage: turns RV32I loads/stores into req/gnt/rvalid data-memory transactions
// and hands a single-cycle result record to writeback.
module mem_access #(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_data_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] data_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [7:0] TIMEOUT_LAST = 8'(RESP_TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [31:0] held_instr;
    logic [31:0] held_alu;
    logic        held_load;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        misaligned;
    logic        accept;
    logic        start_bus;
    logic        pass_through;
    logic        resp_done;
    logic        resp_timeout;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign offset = alu_result_i[1:0];

    // Only the funct3 codes RV32I defines count as memory ops; anything else flows through untouched.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        if (opcode == OP_LOAD) begin
            is_load = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                      (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        if (opcode == OP_STORE) begin
            is_store = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
    end

    assign is_mem = is_load || is_store;

    always_comb begin
        misaligned = 1'b0;
        if (is_mem) begin
            if (funct3[1:0] == 2'b01) begin
                misaligned = offset[0];
            end else if (funct3[1:0] == 2'b10) begin
                misaligned = (offset != 2'b00);
            end
        end
    end

    assign stall_o      = (state != ST_IDLE);
    assign dmem_req_o   = (state == ST_REQ);
    assign accept       = valid_i && (state == ST_IDLE);
    assign start_bus    = accept && is_mem && !misaligned;
    assign pass_through = accept && !start_bus;
    assign resp_done    = (state == ST_WAIT) && dmem_rvalid_i;
    assign resp_timeout = (state == ST_WAIT) && !dmem_rvalid_i && (wait_cnt == TIMEOUT_LAST);

    // Store data is replicated across every lane so the byte enables alone pick the target bytes.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    be_next    = 4'b0001 << offset;
                    wdata_next = {4{rs2_data_i[7:0]}};
                end
                F3_H: begin
                    be_next    = 4'b0011 << offset;
                    wdata_next = {2{rs2_data_i[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = rs2_data_i;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wait_cnt     <= 8'h0;
            held_instr   <= 32'h0;
            held_alu     <= 32'h0;
            held_load    <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= 4'b0000;
            dmem_addr_o  <= 32'h0;
            dmem_wdata_o <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_bus) begin
                        state        <= ST_REQ;
                        held_instr   <= instr_i;
                        held_alu     <= alu_result_i;
                        held_load    <= is_load;
                        dmem_we_o    <= is_store;
                        dmem_be_o    <= be_next;
                        dmem_addr_o  <= {alu_result_i[31:2], 2'b00};
                        dmem_wdata_o <= wdata_next;
                    end
                end
                ST_REQ: begin
                    // Bus fields are cleared once granted so they read as idle while waiting.
                    if (dmem_gnt_i) begin
                        state        <= ST_WAIT;
                        wait_cnt     <= 8'h0;
                        dmem_we_o    <= 1'b0;
                        dmem_be_o    <= 4'b0000;
                        dmem_addr_o  <= 32'h0;
                        dmem_wdata_o <= 32'h0;
                    end
                end
                ST_WAIT: begin
                    if (resp_done || resp_timeout) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 8'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Writeback record: a one-cycle pulse, all-zero whenever nothing completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o      <= 1'b0;
            instr_o      <= 32'h0;
            alu_result_o <= 32'h0;
            data_o       <= 32'h0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            valid_o      <= 1'b0;
            instr_o      <= 32'h0;
            alu_result_o <= 32'h0;
            data_o       <= 32'h0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
            if (pass_through) begin
                valid_o      <= 1'b1;
                instr_o      <= instr_i;
                alu_result_o <= alu_result_i;
                misaligned_o <= misaligned;
            end else if (resp_done) begin
                valid_o      <= 1'b1;
                instr_o      <= held_instr;
                alu_result_o <= held_alu;
                data_o       <= held_load ? dmem_rdata_i : 32'h0;
            end else if (resp_timeout) begin
                valid_o      <= 1'b1;
                instr_o      <= held_instr;
                alu_result_o <= held_alu;
                bus_err_o    <= 1'b1;
            end
        end
    end

endmodule
